// File: rtl/mulu.sv
// rtl/mulu.sv - sequential unsigned radix-2 shift-add multiplier, 2*WIDTH-bit product
// Optional early termination on an exhausted multiplier: define MULU_EARLY_TERM_EN.
module mulu #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               done_q, done_d;
  logic               last_step;

  // Operands are latched on acceptance so the inputs may change during RUN.
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = {{WIDTH{1'b0}}, multiplicand};
          mplr_d  = multiplier;
          acc_d   = '0;
          count_d = '0;
        end
      end
      RUN: begin
        if (mplr_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        count_d = count_q + 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MULU_EARLY_TERM_EN
  assign last_step = (state_q == RUN) &&
                     ((count_d == CW'(WIDTH)) || (mplr_d == '0));
`else
  assign last_step = (state_q == RUN) && (count_d == CW'(WIDTH));
`endif

  // product only moves on the finishing edge, so partial sums never show.
  assign product_d = last_step ? acc_d : product_q;
  assign done_d    = last_step;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = RUN;
      RUN:     if (last_step) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    busy    = (state_q == RUN);
    done    = done_q;
    product = product_q;
  end

endmodule

// File: tb/tb_mulu.sv
// tb/tb_mulu.sv - randomized self-checking bench for mulu against an arithmetic reference
module tb_mulu;

  localparam int W = 32;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a_in  = '0;
  logic [W-1:0]   b_in  = '0;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  int n_checks   = 0;
  int n_fail     = 0;
  int done_count = 0;

  mulu #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .multiplicand (a_in),
    .multiplier   (b_in),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (done) begin
      done_count++;
      check("busy_done_exclusive", {63'd0, busy}, 64'd0);
    end
  end

  function automatic logic [63:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] aa, bb;
    aa = {32'd0, a};
    bb = {32'd0, b};
    return aa * bb;
  endfunction

  function automatic int ref_latency(input logic [W-1:0] b);
`ifdef MULU_EARLY_TERM_EN
    int hi = 0;
    for (int i = 0; i < W; i++) if (b[i]) hi = i + 1;
    return (hi < 1) ? 1 : hi;
`else
    return W;
`endif
  endfunction

  // poke_cyc >= 0 pulses a second start with different operands mid-operation.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag,
                        input int poke_cyc, output logic [63:0] res);
    logic [63:0] prev;
    int cyc;
    @(posedge clock); #1;
    a_in = a; b_in = b; start = 1'b1;
    prev = product;
    @(posedge clock); #1;
    start = 1'b0;
    a_in = $urandom; b_in = $urandom;
    cyc = 0;
    check({tag, "_busy_after_e0"}, {63'd0, busy}, 64'd1);
    while (!done && cyc < 4 * W) begin
      start = (cyc == poke_cyc);
      if (product !== prev) check({tag, "_product_held"}, product, prev);
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(ref_latency(b)));
    check({tag, "_product"}, product, ref_product(a, b));
    check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    res = product;
    @(posedge clock); #1;
    check({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    check({tag, "_product_kept"}, product, ref_product(a, b));
  endtask

  initial begin
    logic [63:0] res;
    logic [W-1:0] ra, rb;
    int base, c1, c2, cyc;

    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    run_op(32'h7fffffff, 32'hffffffff, "max_b", -1, res);
    check("max_b_value", res, 64'h7ffffffe_80000001);
    run_op(32'haaaaaaaa, 32'h7fffffff, "alt_a", -1, res);
    check("alt_a_value", res, 64'h55555554_55555556);
    run_op(32'hffffffff, 32'hffffffff, "all_ones", -1, res);
    check("all_ones_value", res, 64'hfffffffe_00000001);
    run_op(32'h0, 32'hffffffff, "zero_a", -1, res);
    run_op(32'h12345678, 32'h0, "zero_b", -1, res);
    run_op(32'h12345678, 32'h1, "one_b", -1, res);

    base = done_count;
    run_op(32'hdeadbeef, 32'hffffffff, "ignored_start", 10, res);
    repeat (W + 4) @(posedge clock);
    #1 check("ignored_start_done_count", 64'(done_count - base), 64'd1);
    check("ignored_start_idle", {63'd0, busy}, 64'd0);

    // Reset mid-operation, away from a clock edge.
    @(posedge clock); #1;
    a_in = 32'hcafef00d; b_in = 32'hffffffff; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    base = done_count;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (W + 8) @(posedge clock);
    #1 check("abort_no_done", 64'(done_count - base), 64'd0);
    run_op(32'd3, 32'd5, "post_reset", -1, res);
    check("post_reset_value", res, 64'd15);

    // Divider cross-check: 0xaaaaaaaa / 0x7fffffff = 1 rem 0x2aaaaaab.
    run_op(32'd1, 32'h7fffffff, "divu_xchk", -1, res);
    check("divu_xchk_sum", res + 64'h2aaaaaab, 64'h00000000_aaaaaaaa);

    // start held high: next op accepted one cycle after done.
    @(posedge clock); #1;
    a_in = 32'h0badf00d; b_in = 32'h00ff00ff; start = 1'b1;
    @(posedge clock); #1;
    cyc = 0; c1 = -1; c2 = -1;
    while (c2 < 0 && cyc < 6 * W) begin
      @(posedge clock); #1;
      cyc++;
      if (done) begin
        if (c1 < 0) c1 = cyc; else c2 = cyc;
        check("b2b_product", product, ref_product(32'h0badf00d, 32'h00ff00ff));
      end
    end
    start = 1'b0;
    check("b2b_first_latency", 64'(c1), 64'(ref_latency(32'h00ff00ff)));
    check("b2b_spacing", 64'(c2 - c1), 64'(ref_latency(32'h00ff00ff) + 1));

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op(ra, rb, "random", -1, res);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
